cache_refill_arbiter: RTL and testbench
=======================================

// Module: cache_refill_arbiter
// PURPOSE
//  Shares the single main-memory port between I-cache refills and D-cache refills/write-backs.
//  Sits below both caches; its busy/grant state gates INSTRUCTION_CACHE_READY / DATA_CACHE_READY,
//  which drive the hazard control unit's pipeline stalls. Line-granular bursts, one owner at a time.
// PARAMETERS
//  ADDRESS_WIDTH    32  byte address width
//  DATA_WIDTH       32  memory beat width
//  BURST_LEN        8   beats per cache line (power of 2, >=2)
//  BEAT_CNT_WIDTH   3   log2(BURST_LEN)
// PORTS
//  CLK              in   1    clock, rising edge
//  RST_N            in   1    asynchronous active-low reset
//  I_REQ_VALID      in   1    I-cache line-read request
//  I_REQ_ADDRESS    in   AW   I-cache miss address
//  I_REQ_READY      out  1    1-cycle pulse: I request granted
//  I_RDATA_VALID    out  1    read beat for I-cache on RDATA
//  I_RDATA_LAST     out  1    final I beat
//  D_REQ_VALID      in   1    D-cache request
//  D_REQ_WRITE      in   1    1 = write-back line, 0 = refill line
//  D_REQ_ADDRESS    in   AW   D-cache line address
//  D_REQ_READY      out  1    1-cycle pulse: D request granted
//  D_WDATA          in   DW   write-back beat (held until acked)
//  D_WDATA_ACK      out  1    current write beat consumed
//  D_RDATA_VALID    out  1    read beat for D-cache on RDATA
//  D_RDATA_LAST     out  1    final D beat (read or write)
//  RDATA            out  DW   registered read beat, shared by both caches
//  MEM_REQ_VALID    out  1    burst command valid
//  MEM_REQ_READY    in   1    memory accepts command
//  MEM_REQ_WRITE    out  1    command direction
//  MEM_REQ_ADDRESS  out  AW   line-aligned burst address
//  MEM_WDATA        out  DW   = D_WDATA (combinational)
//  MEM_WDATA_VALID  out  1    high throughout WRITE_BURST
//  MEM_WDATA_READY  in   1    memory accepts write beat
//  MEM_RDATA        in   DW   read beat
//  MEM_RDATA_VALID  in   1    read beat valid
//  BUSY             out  1    state != IDLE
//  GRANT_OWNER      out  1    0 = I-cache, 1 = D-cache (valid while BUSY)
// BEHAVIOUR
//  Reset: all outputs 0, RDATA 0, state IDLE, beat count 0, last_owner = D (I wins first tie).
//  FSM: IDLE -> CMD -> READ_BURST | WRITE_BURST -> IDLE.
//  IDLE: if any VALID, grant; pulse that requester's READY; latch owner, write flag,
//   address with low log2(BURST_LEN*DW/8) bits cleared; -> CMD next cycle.
//  Tie (both VALID): round-robin, grant the requester not in last_owner; update last_owner.
//  Requester deasserts VALID after READY; VALID is not re-sampled until back in IDLE.
//  CMD: MEM_REQ_VALID=1 with latched addr/write until MEM_REQ_READY; -> burst state.
//  READ_BURST: each MEM_RDATA_VALID registers MEM_RDATA into RDATA and pulses owner's
//   *_RDATA_VALID next cycle (1-cycle latency); count++; BURST_LEN-th beat also asserts
//   owner's *_RDATA_LAST with it and returns to IDLE the same cycle LAST is driven.
//  WRITE_BURST: MEM_WDATA_VALID=1; D_WDATA_ACK = MEM_WDATA_VALID & MEM_WDATA_READY;
//   count++ per ack; ack of beat BURST_LEN pulses D_RDATA_LAST, -> IDLE.
//  Counter wraps BURST_LEN-1 -> 0 on the last beat; never exceeds BURST_LEN beats.
//  MEM_RDATA_VALID outside READ_BURST: ignored, RDATA unchanged.
//  New VALID arriving during a burst: waits; arbitration only in IDLE (back-to-back min 1 idle cycle).
//  Async reset mid-burst: immediate IDLE, outputs 0; partial burst dropped, memory also reset.
// CONFIGURATION
//  CACHE_REFILL_DPRIO_EN defined: fixed priority, D-cache always wins ties; last_owner unused.
//  Undefined: round-robin as above.
// STRUCTURE
//  Package cache_refill_pkg: state encoding (IDLE/CMD/READ_BURST/WRITE_BURST),
//   OWNER_I=1'b0 / OWNER_D=1'b1, line offset width function.
//  Sub-module refill_beat_counter: BEAT_CNT_WIDTH counter, inc/clear inputs, LAST flag output.
// TESTING
//  I-only read, addr 0x1004 -> MEM_REQ_ADDRESS 0x1000, 8 beats 0xA0..0xA7 -> I_RDATA_VALID x8, LAST on 0xA7.
//  Both VALID after reset -> I granted first; next tie -> D granted; DPRIO_EN build -> D both times.
//  D write-back, MEM_WDATA_READY toggling 1/0 -> exactly 8 D_WDATA_ACK, LAST on 8th, data order kept.
//  MEM_REQ_READY held low 5 cycles -> MEM_REQ_VALID/addr stable all 5, no READY pulses repeated.
//  Spurious MEM_RDATA_VALID in IDLE and WRITE_BURST -> no *_RDATA_VALID, RDATA unchanged.
//  RST_N low at beat 3 of read -> BUSY=0, all outputs 0 asynchronously; next request starts count at 0.

Source files
------------

// File: rtl/cache_refill_pkg.sv
// Shared types and helpers for the cache refill arbiter: FSM state encoding,
// owner encoding and the cache-line offset width.
package cache_refill_pkg;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_CMD         = 2'd1,
      ST_READ_BURST  = 2'd2,
      ST_WRITE_BURST = 2'd3
   } state_t;

   localparam logic OWNER_I = 1'b0;
   localparam logic OWNER_D = 1'b1;

   // Number of byte-address bits covered by one cache line.
   function automatic int line_offset_width(input int burst_len, input int data_width);
      return $clog2(burst_len * data_width / 8);
   endfunction

endpackage

// File: rtl/cache_refill_arbiter_beat_counter.sv
// Beat counter for one line burst. Counts accepted beats and flags the final
// beat; the count is a power of two so it wraps to zero on that final beat.
module refill_beat_counter #(
   parameter int BEAT_CNT_WIDTH = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic inc,
   output logic last
);

   logic [BEAT_CNT_WIDTH-1:0] count;

   // Beat count register: cleared between bursts, advanced per accepted beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc) begin
         count <= count + BEAT_CNT_WIDTH'(1);
      end
   end

   assign last = &count;

endmodule

// File: rtl/cache_refill_arbiter.sv
// Cache refill arbiter: shares the single main-memory burst port between
// I-cache line refills and D-cache line refills / write-backs.
// Build option: define CACHE_REFILL_DPRIO_EN for fixed D-cache priority on
// ties; otherwise ties are resolved round-robin.
//
// Handshakes: a request is granted in IDLE by a one-cycle *_REQ_READY pulse
// while its *_REQ_VALID is high; the requester drops VALID after that pulse.
// MEM_REQ_VALID stays high with stable command until MEM_REQ_READY; a write
// beat transfers in every cycle where MEM_WDATA_VALID and MEM_WDATA_READY are
// both high (reported as D_WDATA_ACK). Read beats have no back-pressure.
module cache_refill_arbiter
   import cache_refill_pkg::*;
#(
   parameter int ADDRESS_WIDTH  = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int BURST_LEN      = 8,
   parameter int BEAT_CNT_WIDTH = 3
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     I_REQ_VALID,
   input  logic [ADDRESS_WIDTH-1:0] I_REQ_ADDRESS,
   output logic                     I_REQ_READY,
   output logic                     I_RDATA_VALID,
   output logic                     I_RDATA_LAST,
   input  logic                     D_REQ_VALID,
   input  logic                     D_REQ_WRITE,
   input  logic [ADDRESS_WIDTH-1:0] D_REQ_ADDRESS,
   output logic                     D_REQ_READY,
   input  logic [DATA_WIDTH-1:0]    D_WDATA,
   output logic                     D_WDATA_ACK,
   output logic                     D_RDATA_VALID,
   output logic                     D_RDATA_LAST,
   output logic [DATA_WIDTH-1:0]    RDATA,
   output logic                     MEM_REQ_VALID,
   input  logic                     MEM_REQ_READY,
   output logic                     MEM_REQ_WRITE,
   output logic [ADDRESS_WIDTH-1:0] MEM_REQ_ADDRESS,
   output logic [DATA_WIDTH-1:0]    MEM_WDATA,
   output logic                     MEM_WDATA_VALID,
   input  logic                     MEM_WDATA_READY,
   input  logic [DATA_WIDTH-1:0]    MEM_RDATA,
   input  logic                     MEM_RDATA_VALID,
   output logic                     BUSY,
   output logic                     GRANT_OWNER,
   output state_t                   STATE_DEBUG
);

   localparam int OFFSET_WIDTH = line_offset_width(BURST_LEN, DATA_WIDTH);
   localparam logic [ADDRESS_WIDTH-1:0] OFFSET_MASK =
      ADDRESS_WIDTH'((64'd1 << OFFSET_WIDTH) - 64'd1);

   state_t                   state, state_next;
   logic                     owner_q, write_q;
   logic [ADDRESS_WIDTH-1:0] addr_q;
   logic                     grant_valid, grant_d, tie_pick_d;
   logic                     beat_clear, beat_inc, beat_last;
   logic                     i_ready_c, d_ready_c, mem_req_valid_c, mem_wdata_valid_c;
   logic                     read_beat, write_ack;
   logic [DATA_WIDTH-1:0]    rdata_q;
   logic                     i_rvalid_q, i_rlast_q, d_rvalid_q, d_rlast_q;

`ifdef CACHE_REFILL_DPRIO_EN
   assign tie_pick_d = 1'b1;
`else
   logic last_owner_q;
   assign tie_pick_d = (last_owner_q == OWNER_I);
`endif

   assign grant_valid = I_REQ_VALID | D_REQ_VALID;
   assign grant_d     = D_REQ_VALID & (~I_REQ_VALID | tie_pick_d);

   // Next-state and per-state strobes; arbitration happens only in IDLE.
   always_comb begin
      state_next        = state;
      i_ready_c         = 1'b0;
      d_ready_c         = 1'b0;
      mem_req_valid_c   = 1'b0;
      mem_wdata_valid_c = 1'b0;
      beat_clear        = 1'b0;
      beat_inc          = 1'b0;
      case (state)
         ST_IDLE: begin
            beat_clear = 1'b1;
            if (grant_valid) begin
               i_ready_c  = ~grant_d;
               d_ready_c  = grant_d;
               state_next = ST_CMD;
            end
         end
         ST_CMD: begin
            mem_req_valid_c = 1'b1;
            if (MEM_REQ_READY) state_next = write_q ? ST_WRITE_BURST : ST_READ_BURST;
         end
         ST_READ_BURST: begin
            if (MEM_RDATA_VALID) begin
               beat_inc = 1'b1;
               if (beat_last) state_next = ST_IDLE;
            end
         end
         ST_WRITE_BURST: begin
            mem_wdata_valid_c = 1'b1;
            if (MEM_WDATA_READY) begin
               beat_inc = 1'b1;
               if (beat_last) state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Latch the winning request's owner, direction and line-aligned address.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         owner_q <= OWNER_I;
         write_q <= 1'b0;
         addr_q  <= '0;
      end else if (state == ST_IDLE && grant_valid) begin
         owner_q <= grant_d;
         write_q <= grant_d & D_REQ_WRITE;
         addr_q  <= (grant_d ? D_REQ_ADDRESS : I_REQ_ADDRESS) & ~OFFSET_MASK;
      end
   end

`ifndef CACHE_REFILL_DPRIO_EN
   // Round-robin history, moved only when both caches contend.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) last_owner_q <= OWNER_D;
      else if (state == ST_IDLE && I_REQ_VALID && D_REQ_VALID) last_owner_q <= grant_d;
   end
`endif

   assign read_beat = (state == ST_READ_BURST) & MEM_RDATA_VALID;
   assign write_ack = mem_wdata_valid_c & MEM_WDATA_READY;

   // Register each read beat and steer its valid/last strobes to the owner.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rdata_q    <= '0;
         i_rvalid_q <= 1'b0;
         i_rlast_q  <= 1'b0;
         d_rvalid_q <= 1'b0;
         d_rlast_q  <= 1'b0;
      end else begin
         i_rvalid_q <= read_beat & (owner_q == OWNER_I);
         i_rlast_q  <= read_beat & (owner_q == OWNER_I) & beat_last;
         d_rvalid_q <= read_beat & (owner_q == OWNER_D);
         d_rlast_q  <= read_beat & (owner_q == OWNER_D) & beat_last;
         if (read_beat) rdata_q <= MEM_RDATA;
      end
   end

   refill_beat_counter #(
      .BEAT_CNT_WIDTH (BEAT_CNT_WIDTH)
   ) u_beat_counter (
      .clk   (CLK),
      .rst_n (RST_N),
      .clear (beat_clear),
      .inc   (beat_inc),
      .last  (beat_last)
   );

   assign I_REQ_READY     = i_ready_c;
   assign D_REQ_READY     = d_ready_c;
   assign I_RDATA_VALID   = i_rvalid_q;
   assign I_RDATA_LAST    = i_rlast_q;
   assign D_RDATA_VALID   = d_rvalid_q;
   assign D_RDATA_LAST    = d_rlast_q | (write_ack & beat_last);
   assign D_WDATA_ACK     = write_ack;
   assign RDATA           = rdata_q;
   assign MEM_REQ_VALID   = mem_req_valid_c;
   assign MEM_REQ_WRITE   = mem_req_valid_c & write_q;
   assign MEM_REQ_ADDRESS = mem_req_valid_c ? addr_q : '0;
   assign MEM_WDATA       = D_WDATA;
   assign MEM_WDATA_VALID = mem_wdata_valid_c;
   assign BUSY            = (state != ST_IDLE);
   assign GRANT_OWNER     = BUSY & owner_q;
   assign STATE_DEBUG     = state;

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Testbench for cache_refill_arbiter: randomized I/D requests against a
// request-level reference model, a responsive memory model and a scoreboard.
module tb_cache_refill_arbiter;
   import cache_refill_pkg::*;

   localparam int BL         = 8;
   localparam int LINE_BYTES = BL * 32 / 8;

   // ---------------- clock / reset ----------------
   logic CLK   = 1'b0;
   logic RST_N = 1'b1;
   always #5 CLK = ~CLK;

   logic        I_REQ_VALID, I_REQ_READY, I_RDATA_VALID, I_RDATA_LAST;
   logic [31:0] I_REQ_ADDRESS;
   logic        D_REQ_VALID, D_REQ_WRITE, D_REQ_READY, D_WDATA_ACK, D_RDATA_VALID, D_RDATA_LAST;
   logic [31:0] D_REQ_ADDRESS, D_WDATA, RDATA;
   logic        MEM_REQ_VALID, MEM_REQ_READY, MEM_REQ_WRITE;
   logic [31:0] MEM_REQ_ADDRESS, MEM_WDATA, MEM_RDATA;
   logic        MEM_WDATA_VALID, MEM_WDATA_READY, MEM_RDATA_VALID;
   logic        BUSY, GRANT_OWNER;
   state_t      STATE_DEBUG;

   cache_refill_arbiter dut (
      .CLK(CLK), .RST_N(RST_N),
      .I_REQ_VALID(I_REQ_VALID), .I_REQ_ADDRESS(I_REQ_ADDRESS), .I_REQ_READY(I_REQ_READY),
      .I_RDATA_VALID(I_RDATA_VALID), .I_RDATA_LAST(I_RDATA_LAST),
      .D_REQ_VALID(D_REQ_VALID), .D_REQ_WRITE(D_REQ_WRITE), .D_REQ_ADDRESS(D_REQ_ADDRESS),
      .D_REQ_READY(D_REQ_READY), .D_WDATA(D_WDATA), .D_WDATA_ACK(D_WDATA_ACK),
      .D_RDATA_VALID(D_RDATA_VALID), .D_RDATA_LAST(D_RDATA_LAST), .RDATA(RDATA),
      .MEM_REQ_VALID(MEM_REQ_VALID), .MEM_REQ_READY(MEM_REQ_READY), .MEM_REQ_WRITE(MEM_REQ_WRITE),
      .MEM_REQ_ADDRESS(MEM_REQ_ADDRESS), .MEM_WDATA(MEM_WDATA), .MEM_WDATA_VALID(MEM_WDATA_VALID),
      .MEM_WDATA_READY(MEM_WDATA_READY), .MEM_RDATA(MEM_RDATA), .MEM_RDATA_VALID(MEM_RDATA_VALID),
      .BUSY(BUSY), .GRANT_OWNER(GRANT_OWNER), .STATE_DEBUG(STATE_DEBUG)
   );

   // ---------------- scoreboard state ----------------
   int          total = 0;
   int          bad   = 0;
   logic [0:0]  exp_grant_q[$];   // owner
   logic [33:0] exp_cmd_q[$];     // {owner, write, line address}
   logic [33:0] exp_rd_q[$];      // {owner, last, data}
   logic [32:0] exp_wr_q[$];      // {last, data}
   logic [31:0] wr_data[BL];
   logic [31:0] rdata_model   = '0;
   logic        model_last_owner = OWNER_D;
   int          rd_left = 0;
   logic [31:0] rd_addr = '0;
   int          stall_cnt = 0;
   int          stall_target = 0;
   bit          force_stall5 = 1'b0;
   bit          wr_toggle = 1'b0;
   bit          done = 1'b0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: event not expected or not seen (t=%0t)", name, $time);
   endfunction

   // Contents of the memory model: a fixed pattern at 0x1000, a hash elsewhere.
   function automatic logic [31:0] mem_word(input logic [31:0] a, input int k);
      if (a == 32'h1000) return 32'hA0 + 32'(k);
      return a ^ (32'(k) * 32'h01010101) ^ 32'h5A5A0000;
   endfunction

   // Reference arbitration for a simultaneous request pair.
   function automatic logic tie_winner();
`ifdef CACHE_REFILL_DPRIO_EN
      return OWNER_D;
`else
      logic w;
      w = (model_last_owner == OWNER_D) ? OWNER_I : OWNER_D;
      model_last_owner = w;
      return w;
`endif
   endfunction

   function automatic void push_expect(input logic owner, input logic wr, input logic [31:0] addr);
      logic [31:0] line;
      line = (addr / LINE_BYTES) * LINE_BYTES;
      exp_grant_q.push_back(owner);
      exp_cmd_q.push_back({owner, wr, line});
      for (int k = 0; k < BL; k++) begin
         if (wr) exp_wr_q.push_back({k == BL - 1, wr_data[k]});
         else    exp_rd_q.push_back({owner, k == BL - 1, mem_word(line, k)});
      end
   endfunction

   function automatic void clear_model();
      exp_grant_q.delete();
      exp_cmd_q.delete();
      exp_rd_q.delete();
      exp_wr_q.delete();
      rdata_model      = '0;
      model_last_owner = OWNER_D;
      rd_left          = 0;
      stall_cnt        = 0;
   endfunction

   // ---------------- memory model (drives on posedge + 1) ----------------
   initial begin
      MEM_REQ_READY = 1'b0; MEM_RDATA_VALID = 1'b0; MEM_RDATA = '0; MEM_WDATA_READY = 1'b0;
      forever begin
         @(posedge CLK); #1;
         if (!RST_N) begin
            MEM_REQ_READY = 1'b0; MEM_RDATA_VALID = 1'b0; MEM_WDATA_READY = 1'b0;
            stall_cnt = 0;
            continue;
         end
         if (MEM_REQ_VALID) begin
            if (stall_cnt >= (force_stall5 ? 5 : stall_target)) MEM_REQ_READY = 1'b1;
            else begin MEM_REQ_READY = 1'b0; stall_cnt++; end
         end else begin
            MEM_REQ_READY = 1'b0;
            stall_cnt     = 0;
         end
         MEM_WDATA_READY = wr_toggle ? ~MEM_WDATA_READY : 1'($urandom_range(0, 1));
         if (rd_left > 0 && $urandom_range(0, 3) != 0) begin
            MEM_RDATA_VALID = 1'b1;
            MEM_RDATA       = mem_word(rd_addr, BL - rd_left);
            rd_left--;
         end else if (rd_left == 0 && $urandom_range(0, 5) == 0) begin
            MEM_RDATA_VALID = 1'b1;       // spurious beat, must be ignored
            MEM_RDATA       = $urandom;
         end else begin
            MEM_RDATA_VALID = 1'b0;
            MEM_RDATA       = $urandom;
         end
      end
   end

   // ---------------- monitor / scoreboard (samples on negedge) ----------------
   initial begin
      logic [33:0] e34;
      logic [32:0] e33;
      logic [0:0]  eg;
      forever begin
         @(negedge CLK);
         if (!RST_N || done) continue;
         if (I_REQ_READY || D_REQ_READY) begin
            if (I_REQ_READY && D_REQ_READY) fail_now("double_grant");
            else if (exp_grant_q.size() == 0) fail_now("grant_unexpected");
            else begin
               eg = exp_grant_q.pop_front();
               check("grant_owner", 64'(D_REQ_READY), 64'(eg));
            end
         end
         if (MEM_REQ_VALID) begin
            if (exp_cmd_q.size() == 0) fail_now("cmd_unexpected");
            else begin
               check("cmd", 64'({GRANT_OWNER, MEM_REQ_WRITE, MEM_REQ_ADDRESS, BUSY}),
                     64'({exp_cmd_q[0], 1'b1}));
               if (MEM_REQ_READY) begin
                  e34 = exp_cmd_q.pop_front();
                  if (!e34[32]) begin
                     rd_left = BL;
                     rd_addr = MEM_REQ_ADDRESS;
                  end
                  stall_target = $urandom_range(0, 3);
               end
            end
         end
         if (I_RDATA_VALID || D_RDATA_VALID) begin
            if (I_RDATA_VALID && D_RDATA_VALID) fail_now("double_rvalid");
            else if (exp_rd_q.size() == 0) fail_now("rbeat_unexpected");
            else begin
               e34 = exp_rd_q.pop_front();
               check("rbeat", 64'({D_RDATA_VALID, D_RDATA_VALID ? D_RDATA_LAST : I_RDATA_LAST, RDATA}),
                     64'(e34));
               rdata_model = e34[31:0];
            end
         end else begin
            check("rdata_hold", 64'({I_RDATA_LAST, RDATA}), 64'({1'b0, rdata_model}));
         end
         if (D_WDATA_ACK) begin
            if (exp_wr_q.size() == 0) fail_now("wack_unexpected");
            else begin
               e33 = exp_wr_q.pop_front();
               check("wbeat", 64'({D_RDATA_LAST, MEM_WDATA}), 64'(e33));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_i(input logic [31:0] addr);
      bit got;
      got = 1'b0;
      I_REQ_VALID = 1'b1; I_REQ_ADDRESS = addr;
      for (int c = 0; c < 500; c++) begin
         @(negedge CLK);
         if (I_REQ_READY) begin got = 1'b1; break; end
      end
      if (!got) fail_now("i_ready_timeout");
      @(posedge CLK); #1;
      I_REQ_VALID = 1'b0;
   endtask

   task automatic drive_d(input logic wr, input logic [31:0] addr);
      bit got;
      got = 1'b0;
      D_REQ_VALID = 1'b1; D_REQ_WRITE = wr; D_REQ_ADDRESS = addr; D_WDATA = wr_data[0];
      for (int c = 0; c < 500; c++) begin
         @(negedge CLK);
         if (D_REQ_READY) begin got = 1'b1; break; end
      end
      if (!got) fail_now("d_ready_timeout");
      @(posedge CLK); #1;
      D_REQ_VALID = 1'b0;
      if (wr && got) begin
         for (int k = 0; k < BL; k++) begin
            D_WDATA = wr_data[k];
            got = 1'b0;
            for (int c = 0; c < 200; c++) begin
               @(negedge CLK);
               if (D_WDATA_ACK) begin got = 1'b1; break; end
            end
            if (!got) begin fail_now("wack_timeout"); break; end
            @(posedge CLK); #1;
         end
      end
   endtask

   task automatic drain(input string name);
      bit empty;
      empty = 1'b0;
      for (int c = 0; c < 300; c++) begin
         @(negedge CLK);
         if (exp_grant_q.size() == 0 && exp_cmd_q.size() == 0 &&
             exp_rd_q.size() == 0 && exp_wr_q.size() == 0) begin empty = 1'b1; break; end
      end
      if (!empty) begin
         fail_now(name);
         exp_grant_q.delete(); exp_cmd_q.delete(); exp_rd_q.delete(); exp_wr_q.delete();
      end
      @(posedge CLK); #1;
   endtask

   // kind: 0 = I only, 1 = D only, 2 = both in the same cycle
   task automatic run_round(input int kind, input logic d_wr, input logic [31:0] i_addr,
                            input logic [31:0] d_addr);
      logic w;
      for (int k = 0; k < BL; k++) wr_data[k] = $urandom;
      if (kind == 0) push_expect(OWNER_I, 1'b0, i_addr);
      else if (kind == 1) push_expect(OWNER_D, d_wr, d_addr);
      else begin
         w = tie_winner();
         if (w == OWNER_I) begin
            push_expect(OWNER_I, 1'b0, i_addr);
            push_expect(OWNER_D, d_wr, d_addr);
         end else begin
            push_expect(OWNER_D, d_wr, d_addr);
            push_expect(OWNER_I, 1'b0, i_addr);
         end
      end
      fork
         begin if (kind != 1) drive_i(i_addr); end
         begin if (kind != 0) drive_d(d_wr, d_addr); end
      join
      drain("drain_timeout");
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_ctl"}, 64'({I_REQ_READY, I_RDATA_VALID, I_RDATA_LAST, D_REQ_READY, D_WDATA_ACK,
                                 D_RDATA_VALID, D_RDATA_LAST, MEM_REQ_VALID, MEM_REQ_WRITE,
                                 MEM_WDATA_VALID, BUSY, GRANT_OWNER}), 64'd0);
      check({name, "_data"}, 64'({RDATA, MEM_REQ_ADDRESS}), 64'd0);
      check({name, "_state"}, 64'(STATE_DEBUG), 64'(ST_IDLE));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bit got;
      I_REQ_VALID = 1'b0; I_REQ_ADDRESS = '0;
      D_REQ_VALID = 1'b0; D_REQ_WRITE = 1'b0; D_REQ_ADDRESS = '0; D_WDATA = '0;
      #1 RST_N = 1'b0;
      #2 check_reset_outputs("reset");
      repeat (3) @(posedge CLK);
      @(negedge CLK) RST_N = 1'b1;
      @(posedge CLK); #1;

      run_round(0, 1'b0, 32'h0000_1004, 32'h0);                   // aligned I refill
      run_round(2, 1'b0, $urandom, $urandom);                     // first tie
      run_round(2, 1'b1, $urandom, $urandom);                     // second tie
      wr_toggle = 1'b1;
      run_round(1, 1'b1, 32'h0, $urandom);                        // write-back, toggling ready
      wr_toggle = 1'b0;
      force_stall5 = 1'b1;
      run_round(0, 1'b0, $urandom, 32'h0);                        // command stalled 5 cycles
      run_round(1, 1'b1, 32'h0, $urandom);
      force_stall5 = 1'b0;
      repeat (10) @(posedge CLK);                                 // idle with spurious beats
      #1;

      // Reset in the middle of a read burst.
      for (int k = 0; k < BL; k++) wr_data[k] = '0;
      push_expect(OWNER_I, 1'b0, 32'h0000_2010);
      drive_i(32'h0000_2010);
      got = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge CLK);
         if (exp_rd_q.size() <= BL - 3) begin got = 1'b1; break; end
      end
      if (!got) fail_now("mid_burst_timeout");
      @(posedge CLK); #2;
      RST_N = 1'b0;
      #1 check_reset_outputs("mid_reset");
      clear_model();
      repeat (3) @(posedge CLK);
      @(negedge CLK) RST_N = 1'b1;
      @(posedge CLK); #1;
      run_round(0, 1'b0, $urandom, 32'h0);                        // full burst after reset
      run_round(2, 1'b0, $urandom, $urandom);                     // tie history restarted

      for (int r = 0; r < 40; r++) begin
         wr_toggle = ($urandom_range(0, 3) == 0);
         run_round($urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom, $urandom);
      end

      done = 1'b1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #900000;
      bad++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
